// File: rtl/pipeline_sched_pkg.sv
// Shared types and helpers for the pipeline scheduler.
//   sched_state_t : enable/flush FSM state encoding
//   id_width()    : width of a requester index (at least 1 bit)
package pipeline_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } sched_state_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipeline_sched_rr_arbiter.sv
// Round-robin arbiter with an internal priority pointer.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_req        : per-requester request vector
//   i_enable     : allow a grant this cycle
//   i_update     : load the pointer with the current winner at the next edge
//   o_grant      : one-hot grant, or zero
//   o_winner     : index of the granted requester (0 when no grant)
module rr_arbiter
  import pipeline_sched_pkg::*;
#(
  parameter int unsigned p_reqs = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [p_reqs-1:0]             i_req,
  input  logic                          i_enable,
  input  logic                          i_update,
  output logic [p_reqs-1:0]             o_grant,
  output logic [id_width(p_reqs)-1:0]   o_winner
);

  localparam int unsigned IdW = id_width(p_reqs);

  logic [IdW-1:0] ptr_q;
  logic [IdW-1:0] idx;
  logic           found;

  // Search starts just above the last winner and wraps, so the last winner
  // has lowest priority next time.
  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    found    = 1'b0;
    idx      = '0;
    if (i_enable) begin
      for (int unsigned off = 1; off <= p_reqs; off++) begin
        idx = IdW'((32'(ptr_q) + off) % p_reqs);
        if (!found && i_req[idx]) begin
          found        = 1'b1;
          o_winner     = idx;
          o_grant[idx] = 1'b1;
        end
      end
    end
  end

  // Reset value makes requester 0 the first to be searched.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q <= IdW'(p_reqs - 1);
    end else if (i_update) begin
      ptr_q <= o_winner;
    end
  end

endmodule

// File: rtl/pipeline_sched.sv
// Shares one fixed-latency, non-stallable pipestage chain between requesters.
// A round-robin arbiter issues at most one request per cycle; a shadow shift
// register carries {valid, id} alongside the external chain so results can be
// tagged. An enable/flush FSM gates issue and signals when the chain drains.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_enable       : allow issue while high
//   i_flush        : single-cycle request to stop issue and drain
//   i_req_valid    : per-requester valid
//   i_req_data     : packed request data, requester k at [k*p_width +: p_width]
//   o_req_ready    : one-hot grant, or zero
//   o_pipe_data    : data driven into the chain (0 when nothing issues)
//   i_pipe_data    : chain output
//   o_rsp_valid    : i_pipe_data is a real result
//   o_rsp_id       : requester owning the result
//   o_rsp_data     : pass-through of i_pipe_data
//   o_busy         : results still in flight
//   o_flush_done   : one-cycle pulse when a drain completes
module pipeline_sched
  import pipeline_sched_pkg::*;
#(
  parameter int unsigned p_width  = 32,
  parameter int unsigned p_stages = 8,
  parameter int unsigned p_reqs   = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_enable,
  input  logic                          i_flush,
  input  logic [p_reqs-1:0]             i_req_valid,
  input  logic [p_reqs*p_width-1:0]     i_req_data,
  output logic [p_reqs-1:0]             o_req_ready,
  output logic [p_width-1:0]            o_pipe_data,
  input  logic [p_width-1:0]            i_pipe_data,
  output logic                          o_rsp_valid,
  output logic [id_width(p_reqs)-1:0]   o_rsp_id,
  output logic [p_width-1:0]            o_rsp_data,
  output logic                          o_busy,
  output logic                          o_flush_done
);

  localparam int unsigned IdW  = id_width(p_reqs);
  localparam int unsigned CntW = $clog2(p_stages + 1);

  sched_state_t                   state_q;
  logic [p_reqs-1:0]              grant;
  logic [IdW-1:0]                 winner;
  logic                           arb_en;
  logic                           issue;
  logic                           rsp_valid;
  logic [p_stages-1:0]            vld_q;
  logic [p_stages-1:0][IdW-1:0]   id_q;
  logic [CntW-1:0]                count_q;
  logic [CntW-1:0]                count_d;

  // Flush or a falling enable blocks issue in the very cycle it is seen.
  assign arb_en = (state_q == StRun) && i_enable && !i_flush;

  rr_arbiter #(
    .p_reqs   (p_reqs)
  ) u_arb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_req    (i_req_valid),
    .i_enable (arb_en),
    .i_update (issue),
    .o_grant  (grant),
    .o_winner (winner)
  );

  assign issue       = |grant;
  assign o_req_ready = grant;

  // Grant is one-hot, so OR-ing the masked lanes selects the winner's data.
  always_comb begin
    o_pipe_data = '0;
    for (int unsigned k = 0; k < p_reqs; k++) begin
      if (grant[k]) begin
        o_pipe_data = o_pipe_data | i_req_data[k*p_width +: p_width];
      end
    end
  end

  assign rsp_valid    = vld_q[p_stages-1];
  assign o_rsp_valid  = rsp_valid;
  assign o_rsp_id     = rsp_valid ? id_q[p_stages-1] : '0;
  assign o_rsp_data   = i_pipe_data;
  assign o_busy       = (count_q != '0);
  assign o_flush_done = (state_q == StDone);

  always_comb begin
    count_d = count_q;
    if (issue && !rsp_valid) begin
      count_d = count_q + 1'b1;
    end else if (!issue && rsp_valid) begin
      count_d = count_q - 1'b1;
    end
  end

  // Shadow register mirrors the external chain: never stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q   <= '0;
      id_q    <= '0;
      count_q <= '0;
    end else begin
      vld_q[0] <= issue;
      id_q[0]  <= winner;
      for (int unsigned i = 1; i < p_stages; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
      count_q <= count_d;
    end
  end

  // DRAIN checks the post-update count so DONE lines up with the cycle the
  // last result has retired.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_flush) begin
            state_q <= StDone;
          end else if (i_enable) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (i_flush || !i_enable) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (count_d == '0) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  a_count_bound : assert property (@(posedge i_clk) disable iff (i_rst)
    (count_q <= CntW'(p_stages)));

endmodule

// File: tb/tb_pipeline_sched.sv
module tb_pipeline_sched;

  localparam int unsigned W = 32;
  localparam int unsigned S = 8;
  localparam int unsigned R = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic           flush;
  logic [R-1:0]   req_valid;
  logic [R*W-1:0] req_data;
  logic [R-1:0]   req_ready;
  logic [W-1:0]   pipe_in;
  logic [W-1:0]   pipe_out;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           busy;
  logic           flush_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the external fixed-latency chain.
  logic [W-1:0] chain [S];
  always_ff @(posedge clk) begin
    chain[0] <= pipe_in;
    for (int i = 1; i < S; i++) chain[i] <= chain[i-1];
  end
  assign pipe_out = chain[S-1];

  always #5 clk = ~clk;

  pipeline_sched #(
    .p_width      (W),
    .p_stages     (S),
    .p_reqs       (R)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (enable),
    .i_flush      (flush),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .o_req_ready  (req_ready),
    .o_pipe_data  (pipe_in),
    .i_pipe_data  (pipe_out),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_id     (rsp_id),
    .o_rsp_data   (rsp_data),
    .o_busy       (busy),
    .o_flush_done (flush_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  int exp_id [14] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0, 2, 3};
  int gid    [5]  = '{0, 1, 2, 3, 0};
  int rgid   [6]  = '{1, 2, 3, 0, 1, 2};

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    req_data  = '0;

    // Reset state
    tick;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flush_done", 32'(flush_done), 32'd0);
    check("rst_pipe_data", pipe_in, 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    tick;
    rst = 1'b0;

    // Single requester: req 2, data 0xA5
    enable = 1'b1;
    tick;
    req_data[2*W +: W] = 32'hA5;
    req_valid = 4'b0100;
    #1;
    check("t1_ready", 32'(req_ready), 32'h4);
    check("t1_pipe_data", pipe_in, 32'hA5);
    tick;
    req_valid = '0;
    for (int i = 1; i < 8; i++) begin
      #1;
      check("t1_wait_rsp", 32'(rsp_valid), 32'd0);
      tick;
    end
    #1;
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp_id", 32'(rsp_id), 32'd2);
    check("t1_rsp_data", rsp_data, 32'hA5);
    check("t1_busy", 32'(busy), 32'd1);
    tick;
    #1;
    check("t1_rsp_gone", 32'(rsp_valid), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // Reset restores pointer, then stream: all valid, then req 1 dropped
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    for (int k = 0; k < R; k++) req_data[k*W +: W] = 32'h100 + 32'(k);
    for (int i = 0; i < 22; i++) begin
      req_valid = (i < 8) ? 4'hF : (i < 14) ? 4'hD : 4'h0;
      #1;
      if (i < 14) begin
        check("t2_grant", 32'(req_ready), 32'd1 << exp_id[i]);
        check("t2_pipe_data", pipe_in, 32'h100 + 32'(exp_id[i]));
      end else begin
        check("t2_no_grant", 32'(req_ready), 32'd0);
      end
      if (i >= 8) begin
        check("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t2_rsp_id", 32'(rsp_id), 32'(exp_id[i-8]));
        check("t2_rsp_data", rsp_data, 32'h100 + 32'(exp_id[i-8]));
      end else begin
        check("t2_rsp_idle", 32'(rsp_valid), 32'd0);
      end
      if (i >= 1) check("t2_busy", 32'(busy), 32'd1);
      tick;
    end

    // Flush with 5 in flight
    for (int j = 0; j < 15; j++) begin
      req_valid = 4'hF;
      flush     = (j == 5);
      if (j == 14) begin
        enable    = 1'b0;
        req_valid = '0;
      end
      #1;
      if (j < 5) check("t3_grant", 32'(req_ready), 32'd1 << gid[j]);
      else       check("t3_no_grant", 32'(req_ready), 32'd0);
      if (j >= 8 && j <= 12) begin
        check("t3_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t3_rsp_id", 32'(rsp_id), 32'(gid[j-8]));
      end else begin
        check("t3_rsp_idle", 32'(rsp_valid), 32'd0);
      end
      check("t3_flush_done", 32'(flush_done), 32'(j == 13));
      check("t3_busy", 32'(busy), 32'(j >= 1 && j <= 12));
      tick;
    end
    flush = 1'b0;

    // Flush in IDLE with empty chain
    for (int k = 0; k < 3; k++) begin
      flush     = (k == 0);
      req_valid = 4'hF;
      #1;
      check("t4_no_grant", 32'(req_ready), 32'd0);
      check("t4_flush_done", 32'(flush_done), 32'(k == 1));
      tick;
    end
    flush = 1'b0;

    // Reset with 6 in flight
    enable = 1'b1;
    tick;
    for (int m = 0; m < 6; m++) begin
      #1;
      check("t5_grant", 32'(req_ready), 32'd1 << rgid[m]);
      tick;
    end
    req_valid = '0;
    rst = 1'b1;
    tick;
    rst       = 1'b0;
    enable    = 1'b0;
    req_valid = 4'hF;
    for (int n = 0; n < 10; n++) begin
      #1;
      check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_idle_ready", 32'(req_ready), 32'd0);
      tick;
    end

    // Enable low->high, then low: first grant to req 0, then drain/done
    enable = 1'b1;
    #1;
    check("t6_idle_ready", 32'(req_ready), 32'd0);
    tick;
    #1;
    check("t6_first_grant", 32'(req_ready), 32'd1);
    tick;
    enable = 1'b0;
    #1;
    check("t6_disable_grant", 32'(req_ready), 32'd0);
    tick;
    for (int n = 0; n < 9; n++) begin
      #1;
      check("t6_ready", 32'(req_ready), 32'd0);
      check("t6_rsp_valid", 32'(rsp_valid), 32'(n == 6));
      if (n == 6) begin
        check("t6_rsp_id", 32'(rsp_id), 32'd0);
        check("t6_rsp_data", rsp_data, 32'h100);
      end
      check("t6_flush_done", 32'(flush_done), 32'(n == 7));
      tick;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_sched.md
Name: pipeline_sched

Overview:
- Shares one fixed-latency, non-stallable pipestage chain (p_stages deep, p_width wide) between p_reqs requesters.
- Each cycle, a round-robin arbiter issues at most one request into the chain.
- A shadow shift register carries valid and requester ID alongside the data, so the chain output can be tagged.
- An enable/flush FSM gates issue and reports when the chain has drained.

Parameters:
- p_width, 32, data width of the pipeline.
- p_stages, 8, latency of the attached pipeline in cycles (≥1).
- p_reqs, 4, number of requesters (≥2).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_enable  in  1  allow issue while high.
- i_flush  in  1  single-cycle request to stop issue and drain.
- i_req_valid  in  p_reqs  per-requester valid.
- i_req_data  in  p_reqs*p_width  packed request data; requester k occupies bits [k*p_width +: p_width].
- o_req_ready  out  p_reqs  one-hot grant, or zero.
- o_pipe_data  out  p_width  drives the pipeline input.
- i_pipe_data  in  p_width  pipeline output.
- o_rsp_valid  out  1  i_pipe_data is a real result.
- o_rsp_id  out  $clog2(p_reqs)  requester that owns the result.
- o_rsp_data  out  p_width  equals i_pipe_data (combinational pass-through).
- o_busy  out  1  in-flight count is non-zero.
- o_flush_done  out  1  one-cycle pulse when the drain completes.

Behaviour:
- Reset (synchronous, i_rst high at a clock edge):
  - FSM goes to IDLE.
  - Shadow valids cleared; in-flight count = 0.
  - RR pointer = p_reqs-1, so requester 0 has first priority.
  - All outputs 0 the cycle after reset, except o_rsp_data, which follows i_pipe_data.
- Reset mid-operation discards all in-flight tags. Data still in the chain is ignored because o_rsp_valid = 0.
- FSM states:
  - IDLE: no grants. i_flush → DONE; else i_enable → RUN.
  - RUN: grants allowed. i_flush or !i_enable → DRAIN; no grant is issued in that same cycle (flush has priority over issue).
  - DRAIN: no grants. When in-flight count = 0 → DONE. This takes 0 cycles of waiting if the chain is already empty.
  - DONE: o_flush_done = 1 for this one cycle; → IDLE unconditionally.
  - i_flush while in DRAIN or DONE is ignored.
- Arbitration (RUN only, combinational):
  - Search requesters from pointer+1 upward, wrapping at p_reqs.
  - The first one with i_req_valid wins; o_req_ready has exactly that bit set.
  - Ready depends on valid. A requester must not make valid depend on ready.
  - On a grant, the pointer updates to the winner index at the next edge. With no grant, the pointer holds.
- Issue: o_pipe_data = winner's i_req_data in the grant cycle, else 0. The pipeline captures it at the same edge.
- Latency: a grant in cycle t gives o_rsp_valid = 1, o_rsp_id = winner in cycle t+p_stages, aligned with i_pipe_data.
- Shadow register: p_stages entries of {valid, id}, shifting every cycle, never stalled.
- In-flight count, width $clog2(p_stages+1):
  - +1 on issue, −1 when o_rsp_valid.
  - Both in the same cycle → unchanged.
  - Never exceeds p_stages; an assertion checks this.
- Throughput: one issue per cycle sustained. With all requesters valid, grant order is 0,1,2,…,p_reqs-1,0,…
- o_rsp_valid has no backpressure. The consumer must accept results.

Decomposition:
- pipeline_sched_pkg holds:
  - sched_state_t enum {IDLE, RUN, DRAIN, DONE};
  - a localparam helper for the ID width.
- Sub-module rr_arbiter, parameterised by p_reqs:
  - inputs: request vector, enable, pointer-update strobe;
  - outputs: one-hot grant and winner index;
  - holds the pointer internally, with the same clock and reset.
- The top level instantiates rr_arbiter, the FSM, the shadow shift register and the counter.

Test Plan:
- Single requester, p_stages=8: enable, req 2 valid with data 0xA5 for one cycle → o_req_ready = 0b0100 that cycle; 8 cycles later o_rsp_valid = 1, o_rsp_id = 2, o_rsp_data = 0xA5.
- All 4 valid continuously for 8 cycles → grants 0,1,2,3,0,1,2,3; responses arrive in the same order with o_busy held high. Then drop one requester (req 1): its slot is skipped, giving order 0,2,3.
- Flush with 5 entries in flight: pulse i_flush → no further grants from that cycle; o_flush_done pulses exactly when the last o_rsp_valid has retired (count 0), then IDLE.
- i_flush in IDLE with empty chain → o_flush_done the next cycle; no grants issued.
- Reset asserted with 6 in flight → next cycle o_rsp_valid stays 0 for p_stages cycles, o_busy = 0, state IDLE; after re-enable, the first grant goes to req 0.
- i_enable low → high with reqs valid → first grant one cycle after enable is seen (IDLE→RUN). Then enable low → DRAIN → DONE pulse → IDLE.
